// File: rtl/stepper_ramp_ctrl.sv
// Step/direction sequencer with a trapezoidal speed profile.
// A move is accepted over cmd_valid/cmd_ready. Step pulses are timed directly
// from the system clock. The step interval ramps down from the start period to
// the cruise period, holds, then ramps back up so the last step uses the start
// period again. abort shortens the move to a controlled deceleration.
module stepper_ramp_ctrl #(
  parameter int PERIOD_W = 26,
  parameter int STEP_W   = 16,
  parameter int PULSE_W  = 100
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] start_period,
  input  logic [PERIOD_W-1:0] min_period,
  input  logic [PERIOD_W-1:0] ramp_delta,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STEP_W-1:0]   steps_left
);

  localparam logic [PERIOD_W-1:0] PULSE_LEN = PERIOD_W'(PULSE_W);
  localparam logic [PERIOD_W-1:0] MIN_LEGAL = PERIOD_W'(2 * PULSE_W);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FINISH} state_t;

  function automatic logic [PERIOD_W-1:0] max_p(input logic [PERIOD_W-1:0] a,
                                                input logic [PERIOD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [PERIOD_W-1:0] min_p(input logic [PERIOD_W-1:0] a,
                                                input logic [PERIOD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Lengthen the interval by d, saturating at cap; the sum is one bit wider so it cannot wrap.
  function automatic logic [PERIOD_W-1:0] ramp_up(input logic [PERIOD_W-1:0] p,
                                                  input logic [PERIOD_W-1:0] d,
                                                  input logic [PERIOD_W-1:0] cap);
    logic [PERIOD_W:0] sum;
    sum = {1'b0, p} + {1'b0, d};
    if (sum > {1'b0, cap}) return cap;
    return sum[PERIOD_W-1:0];
  endfunction

  // Shorten the interval by d, saturating at floor; p never sits below floor.
  function automatic logic [PERIOD_W-1:0] ramp_down(input logic [PERIOD_W-1:0] p,
                                                    input logic [PERIOD_W-1:0] d,
                                                    input logic [PERIOD_W-1:0] floor);
    if ((p - floor) > d) return p - d;
    return floor;
  endfunction

  function automatic logic [STEP_W-1:0] dec_sat(input logic [STEP_W-1:0] a);
    return (a == '0) ? a : a - 1'b1;
  endfunction

  // Remaining steps after an abort: just enough to ramp back down from the
  // current speed (one step per acceleration step taken, plus the next one).
  function automatic logic [STEP_W-1:0] clamp_abort(input logic [STEP_W-1:0] left,
                                                    input logic [STEP_W-1:0] acc);
    logic [STEP_W:0] lim;
    lim = {1'b0, acc} + 1'b1;
    if ({1'b0, left} > lim) return lim[STEP_W-1:0];
    return left;
  endfunction

  state_t              state, state_n;
  logic [PERIOD_W-1:0] period, period_n;
  logic [PERIOD_W-1:0] sp, sp_n;
  logic [PERIOD_W-1:0] mp, mp_n;
  logic [PERIOD_W-1:0] delta, delta_n;
  logic [STEP_W-1:0]   accel_cnt, accel_cnt_n;
  logic [PERIOD_W-1:0] icnt, icnt_n;
  logic [PERIOD_W-1:0] hcnt, hcnt_n;
  logic                step_n, dir_n, busy_n, done_n, aborted_n, cmd_ready_n;
  logic [STEP_W-1:0]   steps_left_n;
  logic [STEP_W-1:0]   left_dec;
  logic [PERIOD_W-1:0] sp_cmd, mp_cmd;

  // Start/final interval and cruise interval, both held to the legal minimum.
  assign sp_cmd = max_p(start_period, MIN_LEGAL);
  assign mp_cmd = max_p(min_p(min_period, sp_cmd), MIN_LEGAL);

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    state_n      = state;
    period_n     = period;
    sp_n         = sp;
    mp_n         = mp;
    delta_n      = delta;
    accel_cnt_n  = accel_cnt;
    icnt_n       = icnt;
    hcnt_n       = hcnt;
    step_n       = step;
    dir_n        = dir;
    busy_n       = busy;
    done_n       = 1'b0;
    aborted_n    = aborted;
    steps_left_n = steps_left;
    left_dec     = steps_left - 1'b1;

    // Pulse high-time timer runs regardless of state so the last pulse completes.
    if (step) begin
      if (hcnt == PULSE_LEN) step_n = 1'b0;
      else                   hcnt_n = hcnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dir_n        = cmd_dir;
          steps_left_n = cmd_steps;
          sp_n         = sp_cmd;
          mp_n         = mp_cmd;
          delta_n      = ramp_delta;
          period_n     = sp_cmd;
          accel_cnt_n  = '0;
          aborted_n    = 1'b0;
          busy_n       = 1'b1;
          icnt_n       = PERIOD_W'(1);
          if (cmd_steps == '0)       state_n = FINISH;
          else if (mp_cmd == sp_cmd) state_n = CRUISE;
          else                       state_n = ACCEL;
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (icnt == period) begin
          step_n       = 1'b1;
          hcnt_n       = PERIOD_W'(1);
          icnt_n       = PERIOD_W'(1);
          steps_left_n = left_dec;
          if (left_dec == '0) begin
            state_n = FINISH;
          end else if (state == DECEL || left_dec <= accel_cnt) begin
            state_n     = DECEL;
            period_n    = ramp_up(period, delta, sp);
            accel_cnt_n = dec_sat(accel_cnt);
          end else if (state == ACCEL) begin
            period_n    = ramp_down(period, delta, mp);
            accel_cnt_n = accel_cnt + 1'b1;
            if (period_n == mp) state_n = CRUISE;
          end
        end else begin
          icnt_n = icnt + 1'b1;
        end
        // Abort trims the move after any coincident step has been counted.
        if (abort && state != DECEL) begin
          steps_left_n = clamp_abort(steps_left_n, accel_cnt_n);
          aborted_n    = 1'b1;
        end
      end
      FINISH: begin
        if (!step || hcnt == PULSE_LEN) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE);
  end

  // Control state and outputs, asynchronously cleared.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
      cmd_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      dir        <= dir_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
      steps_left <= steps_left_n;
      cmd_ready  <= cmd_ready_n;
    end
  end

  // Profile datapath; every field is loaded at accept before it is used.
  always_ff @(posedge clock_100Mhz) begin
    period    <= period_n;
    sp        <= sp_n;
    mp        <= mp_n;
    delta     <= delta_n;
    accel_cnt <= accel_cnt_n;
    icnt      <= icnt_n;
    hcnt      <= hcnt_n;
  end

endmodule
